// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - shared types, constants and phase helper for the step-coded phase transmitter
// Purpose: phase and FSM state enums, protocol word codes, mod-NPHASE phase increment.
// Ports: none (package).
package step_seq_pkg;

  localparam int NPHASE    = 3;
  localparam int STEP_CODE = 1;
  localparam int IDLE_CODE = 0;

  typedef enum logic [1:0] {
    CLEAR      = 2'd0,
    ACCUMULATE = 2'd1,
    LOAD       = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DATA = 2'd2
  } tx_state_e;

  function automatic logic [1:0] phase_inc(input logic [1:0] p);
    return (p == 2'(NPHASE - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/step_seq_tx_if.sv
// rtl/step_seq_tx_if.sv - command handshake and emitted-word bundle for step_seq_tx
// Purpose: groups the command valid/ready channel and the emitted word channel.
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_data (command), next/signal (emitted word).
// Modports: master drives commands and observes words; slave is the transmitter.
interface step_seq_tx_if #(
  parameter int W = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         next;
  logic [W-1:0] signal;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, next, signal
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, next, signal
  );
endinterface

// File: rtl/step_seq_phase_track.sv
// rtl/step_seq_phase_track.sv - shadow copy of the receiver phase
// Purpose: holds the phase register, its mod-NPHASE successor and the number of
//   STEP words needed to reach a target phase; reusable on the receive side.
// Ports: i_clk, i_rst_n (async active-low), i_inc (advance phase this cycle),
//   i_target (wanted phase), o_phase, o_phase_inc (phase after one step),
//   o_steps ((target - phase) mod NPHASE).
module step_seq_phase_track
  import step_seq_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic [1:0] i_target,
  output logic [1:0] o_phase,
  output logic [1:0] o_phase_inc,
  output logic [1:0] o_steps
);

  logic [1:0] r_phase;
  logic [2:0] w_diff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= CLEAR;
    end else if (i_inc) begin
      r_phase <= phase_inc(r_phase);
    end
  end

  // Bias by NPHASE so the subtraction never goes negative, then fold once.
  assign w_diff      = {1'b0, i_target} + 3'(NPHASE) - {1'b0, r_phase};
  assign o_steps     = (w_diff >= 3'(NPHASE)) ? 2'(w_diff - 3'(NPHASE)) : 2'(w_diff);
  assign o_phase     = r_phase;
  assign o_phase_inc = phase_inc(r_phase);

endmodule

// File: rtl/step_seq_tx.sv
// rtl/step_seq_tx.sv - step-coded phase protocol transmitter
// Purpose: accepts {op, data} commands, emits STEP words until the receiver
//   reaches the target phase, then one data word; tracks the receiver phase.
// Ports: i_clk, i_rst_n (async active-low), bus (slave: command channel and
//   emitted word), o_phase (shadow phase), o_busy, o_err_op (pulse on op 3),
//   o_word_count (words emitted, wraps).
module step_seq_tx
  import step_seq_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  step_seq_tx_if.slave bus,
  output logic [1:0]   o_phase,
  output logic         o_busy,
  output logic         o_err_op,
  output logic [31:0]  o_word_count
);

  tx_state_e    r_state;
  logic [1:0]   r_op;
  logic [W-1:0] r_data;
  logic [W-1:0] r_signal;
  logic         r_next;
  logic         r_busy;
  logic         r_err_op;
  logic [31:0]  r_word_count;

  tx_state_e    w_state_nxt;
  logic         w_latch;
  logic         w_inc;
  logic         w_err_nxt;
  logic [W-1:0] w_signal_nxt;
  logic [1:0]   w_target;
  logic [1:0]   w_phase;
  logic [1:0]   w_phase_inc;
  logic [1:0]   w_steps;

  // While idle the steps calculation looks at the offered op directly so the
  // first word can go out on the cycle right after acceptance.
  assign w_target = (r_state == IDLE) ? bus.cmd_op : r_op;

  step_seq_phase_track u_phase (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_inc       (w_inc),
    .i_target    (w_target),
    .o_phase     (w_phase),
    .o_phase_inc (w_phase_inc),
    .o_steps     (w_steps)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_inc       = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == 2'd3) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = (w_steps == 2'd0) ? DATA : STEP;
          end
        end
      end
      STEP: begin
        w_inc       = 1'b1;
        w_state_nxt = (w_phase_inc == r_op) ? DATA : STEP;
      end
      DATA: begin
        // A data word equal to the step code also advances the receiver.
        w_inc       = (r_data == W'(STEP_CODE));
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (w_state_nxt)
      STEP:    w_signal_nxt = W'(STEP_CODE);
      DATA:    w_signal_nxt = w_latch ? bus.cmd_data : r_data;
      default: w_signal_nxt = W'(IDLE_CODE);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_op         <= 2'd0;
      r_data       <= '0;
      r_signal     <= W'(IDLE_CODE);
      r_next       <= 1'b0;
      r_busy       <= 1'b0;
      r_err_op     <= 1'b0;
      r_word_count <= 32'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_signal     <= w_signal_nxt;
      r_next       <= (w_state_nxt != IDLE);
      r_busy       <= (w_state_nxt != IDLE);
      r_err_op     <= w_err_nxt;
      r_word_count <= r_word_count + {31'd0, r_next};
      if (w_latch) begin
        r_op   <= bus.cmd_op;
        r_data <= bus.cmd_data;
      end
    end
  end

  assign bus.cmd_ready = (r_state == IDLE) && i_rst_n;
  assign bus.next      = r_next;
  assign bus.signal    = r_signal;
  assign o_phase       = w_phase;
  assign o_busy        = r_busy;
  assign o_err_op      = r_err_op;
  assign o_word_count  = r_word_count;

endmodule
